// File: rtl/ocp_bus_master.sv
// OCP single-outstanding bus master: local req/rsp to OCP MCmd/SResp.
// Ports: clk, rst, i_req_* / o_req_ready, o_rsp_*, OCP M*/S* signals.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_MCMD_IDLE
`define OCP_MCMD_IDLE  3'd0
`define OCP_MCMD_WR    3'd1
`define OCP_MCMD_RD    3'd2
`define OCP_SRESP_NULL 2'd0
`define OCP_SRESP_DVA  2'd1
`define OCP_SRESP_FAIL 2'd2
`define OCP_SRESP_ERR  2'd3
`endif

module ocp_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_wr,
  input  logic [`ADDR_WIDTH-1:0] i_req_addr,
  input  logic [`DATA_WIDTH-1:0] i_req_data,
  input  logic [`BEN_WIDTH-1:0]  i_req_ben,
  output logic                   o_rsp_valid,
  output logic [`DATA_WIDTH-1:0] o_rsp_data,
  output logic                   o_rsp_err,
  output logic [`ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]             o_MCmd,
  output logic [`DATA_WIDTH-1:0] o_MData,
  output logic [`BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                   i_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]             i_SResp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP,
    S_DONE
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [2:0]               mcmd_q, mcmd_d;
  logic [`ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [`DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic [`BEN_WIDTH-1:0]    mben_q, mben_d;
  logic                     rvld_q, rvld_d;
  logic [`DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                     rerr_q, rerr_d;
  logic                     rdy_q, rdy_d;

  logic [15:0] cnt_inc;
  logic        to_hit;
  logic        resp_in;
  logic        clr_m;
  logic        fin;

  assign cnt_inc = cnt_q + 16'd1;
  // cnt_q counts completed cycles in CMD/RESP; abort when this one is the last
  assign to_hit  = (cnt_inc == TO_LIM);
  assign resp_in = (i_SResp != `OCP_SRESP_NULL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcmd_d  = mcmd_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mben_d  = mben_q;
    rvld_d  = 1'b0;
    rdata_d = '0;
    rerr_d  = 1'b0;
    rdy_d   = 1'b0;
    clr_m   = 1'b0;
    fin     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid && rdy_q) begin
          mcmd_d  = i_req_wr ? `OCP_MCMD_WR : `OCP_MCMD_RD;
          maddr_d = i_req_addr;
          mdata_d = i_req_data;
          mben_d  = i_req_ben;
          cnt_d   = '0;
          state_d = S_CMD;
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_CMD: begin
        cnt_d = cnt_inc;
        if (i_SCmdAccept) begin
          clr_m = 1'b1;
          if (mcmd_q == `OCP_MCMD_WR) begin
            // posted write: no response phase
            fin = 1'b1;
          end else if (resp_in) begin
            fin     = 1'b1;
            rdata_d = i_SData;
            rerr_d  = (i_SResp != `OCP_SRESP_DVA);
          end else begin
            state_d = S_RESP;
          end
        end else if (to_hit) begin
          clr_m  = 1'b1;
          fin    = 1'b1;
          rerr_d = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_inc;
        if (resp_in) begin
          fin     = 1'b1;
          rdata_d = i_SData;
          rerr_d  = (i_SResp != `OCP_SRESP_DVA);
        end else if (to_hit) begin
          fin    = 1'b1;
          rerr_d = 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (clr_m) begin
      mcmd_d  = `OCP_MCMD_IDLE;
      maddr_d = '0;
      mdata_d = '0;
      mben_d  = '0;
    end
    if (fin) begin
      state_d = S_DONE;
      rvld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcmd_q  <= `OCP_MCMD_IDLE;
      maddr_q <= '0;
      mdata_q <= '0;
      mben_q  <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcmd_q  <= mcmd_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mben_q  <= mben_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_req_ready = rdy_q;
  assign o_rsp_valid = rvld_q;
  assign o_rsp_data  = rdata_q;
  assign o_rsp_err   = rerr_q;
  assign o_MCmd      = mcmd_q;
  assign o_MAddr     = maddr_q;
  assign o_MData     = mdata_q;
  assign o_MByteEn   = mben_q;

endmodule

// File: doc/ocp_bus_master.md
OCP_BUS_MASTER -- requirements
Module: ocp_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the cycles allowed per transaction in CMD+RESP before abort (1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port i_req_valid, input, 1, local request valid.
REQ-005 SHALL have port o_req_ready, output, 1, request accepted when valid&ready at a rising edge.
REQ-006 SHALL have port i_req_wr, input, 1, 1=write, 0=read.
REQ-007 SHALL have ports i_req_addr, input, `ADDR_WIDTH; i_req_data, input, `DATA_WIDTH; i_req_ben, input, `BEN_WIDTH; the request fields.
REQ-008 SHALL have port o_rsp_valid, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports o_rsp_data, output, `DATA_WIDTH, read data; o_rsp_err, output, 1, error/timeout flag.
REQ-010 SHALL have OCP master ports o_MAddr `ADDR_WIDTH, o_MCmd 3, o_MData `DATA_WIDTH, o_MByteEn `BEN_WIDTH (outputs); i_SCmdAccept 1, i_SData `DATA_WIDTH, i_SResp 2 (inputs); encodings per ocp_const.vh.

Function
REQ-011 SHALL implement states IDLE, CMD, RESP, DONE; all outputs registered.
REQ-012 IDLE: o_req_ready=1; on i_req_valid, SHALL latch request fields, drive o_MCmd=WRITE/READ with o_MAddr/o_MData/o_MByteEn from the next cycle, enter CMD.
REQ-013 CMD: SHALL hold o_MCmd, o_MAddr, o_MData, o_MByteEn stable until i_SCmdAccept sampled 1.
REQ-014 Write accepted: SHALL drive o_MCmd=IDLE, o_MAddr/o_MData/o_MByteEn=0, enter DONE with o_rsp_err=0, o_rsp_data=0 (posted write, no SResp wait).
REQ-015 Read accepted with i_SResp=NULL: SHALL drive o_MCmd=IDLE, zero other M* outputs, enter RESP.
REQ-016 Read accepted with i_SResp!=NULL in the same cycle: SHALL complete directly to DONE, capturing i_SData.
REQ-017 RESP: on i_SResp!=NULL SHALL capture o_rsp_data=i_SData, o_rsp_err=(i_SResp!=DVA), enter DONE.
REQ-018 DONE: o_rsp_valid=1 for exactly one cycle, o_req_ready=0; then IDLE.
REQ-019 Minimum latency: request accept edge N -> o_MCmd valid cycle N+1 -> o_rsp_valid cycle N+2 (write, or read with same-cycle accept+DVA).
REQ-020 Timeout counter SHALL clear on entering CMD and increment each cycle in CMD/RESP; reaching TIMEOUT SHALL force o_MCmd=IDLE and enter DONE with o_rsp_err=1, o_rsp_data=0.
REQ-021 i_SResp!=NULL sampled in IDLE or DONE, or in CMD before accept, SHALL be ignored.
REQ-022 o_req_ready SHALL be 0 in CMD, RESP, DONE; at most one outstanding transaction.
REQ-023 Request fields SHALL be passed unmodified (no alignment or byte-enable checks).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, o_MCmd=IDLE, o_MAddr/o_MData/o_MByteEn=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_req_ready=0, counter=0.
REQ-025 o_req_ready SHALL rise the first cycle after rst deasserts.
REQ-026 rst asserted mid-transaction SHALL abort without an o_rsp_valid pulse; o_MCmd=IDLE from next cycle.

Verification
REQ-027 Write addr 0x000, data 0x000F_FFF0, ben 0xF, slave accepts immediately -> o_MCmd=WRITE one cycle, o_rsp_valid at N+2, err=0.
REQ-028 Read addr 0x004, slave accepts after 3 cycles, DVA with 0x0000_0008 two cycles later -> command held 4 cycles, o_rsp_data=0x0000_0008, err=0.
REQ-029 Read with SResp=ERR -> o_rsp_valid once, o_rsp_err=1, o_rsp_data=SData.
REQ-030 TIMEOUT=8, SCmdAccept held 0 -> o_MCmd=IDLE and o_rsp_valid with err=1, data 0 exactly 8 cycles after command start.
REQ-031 rst pulsed while in RESP -> no o_rsp_valid, M* outputs zero, next request completes normally.
REQ-032 Back-to-back requests with i_req_valid held high -> second accepted only the cycle after DONE; spurious SResp in IDLE ignored.
